// File: rtl/ghost_chase_ctrl.sv
// Ghost chase controller: paces ghost steps from a tick timebase and steers the
// ghost toward Pac-Man through open cells, reporting when the ghost reaches him.
module ghost_chase_ctrl #(
  parameter int         SPEED     = 4,
  parameter logic [1:0] DIR_RESET = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       game_start,
  input  logic [9:0] xGhost,
  input  logic [8:0] yGhost,
  input  logic [9:0] xPac,
  input  logic [8:0] yPac,
  input  logic       open_up,
  input  logic       open_left,
  input  logic       open_down,
  input  logic       open_right,
  output logic       e_start,
  output logic       m_up,
  output logic       m_down,
  output logic       m_left,
  output logic       m_right,
  output logic       caught
);

  typedef enum logic [2:0] {IDLE, START, WAIT, DECIDE, MOVE, SETTLE, CAUGHT} state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam logic [3:0] LAST_TICK = 4'(SPEED - 1);

  state_t      state_q, state_d;
  logic [1:0]  heading_q, heading_d;
  logic [3:0]  tickCnt_q, tickCnt_d;

  logic signed [10:0] dx;
  logic signed [9:0]  dy;
  logic [10:0] absDx;
  logic [9:0]  absDy;
  logic        horizFirst, horizOk, vertOk, primOk, secOk, atPac;
  logic [1:0]  horizDir, vertDir, primDir, secDir, reverseDir, chosenDir;
  logic [3:0]  openMask, nonReverse, cand;

  assign dx    = signed'({1'b0, xPac} - {1'b0, xGhost});
  assign dy    = signed'({1'b0, yPac} - {1'b0, yGhost});
  assign absDx = dx[10] ? 11'(-dx) : 11'(dx);
  assign absDy = dy[9]  ? 10'(-dy) : 10'(dy);
  assign atPac = (xGhost == xPac) && (yGhost == yPac);

  assign horizDir   = dx[10] ? DIR_LEFT : DIR_RIGHT;
  assign vertDir    = dy[9]  ? DIR_UP   : DIR_DOWN;
  assign horizOk    = (dx != 11'sd0);
  assign vertOk     = (dy != 10'sd0);
  assign horizFirst = absDx > {1'b0, absDy};
  assign primDir    = horizFirst ? horizDir : vertDir;
  assign primOk     = horizFirst ? horizOk  : vertOk;
  assign secDir     = horizFirst ? vertDir  : horizDir;
  assign secOk      = horizFirst ? vertOk   : horizOk;

  // Bit index of each mask matches the heading encoding, so reverse is a bit flip.
  assign openMask   = {open_right, open_down, open_left, open_up};
  assign reverseDir = heading_q ^ 2'b10;
  assign nonReverse = openMask & ~(4'b0001 << reverseDir);
  assign cand       = (nonReverse != 4'b0000) ? nonReverse : openMask;

  always_comb begin
    chosenDir = heading_q;
    if (primOk && cand[primDir])      chosenDir = primDir;
    else if (secOk && cand[secDir])   chosenDir = secDir;
    else if (cand[0])                 chosenDir = DIR_UP;
    else if (cand[1])                 chosenDir = DIR_LEFT;
    else if (cand[2])                 chosenDir = DIR_DOWN;
    else if (cand[3])                 chosenDir = DIR_RIGHT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      heading_q <= DIR_RESET;
      tickCnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      tickCnt_q <= tickCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    tickCnt_d = tickCnt_q;
    e_start   = 1'b0;
    m_up      = 1'b0;
    m_down    = 1'b0;
    m_left    = 1'b0;
    m_right   = 1'b0;
    caught    = 1'b0;
    case (state_q)
      IDLE: ;
      START: begin
        e_start   = 1'b1;
        heading_d = DIR_RESET;
        tickCnt_d = 4'd0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (atPac) begin
          state_d = CAUGHT;
        end else if (tick) begin
          if (tickCnt_q == LAST_TICK) begin
            tickCnt_d = 4'd0;
            state_d   = DECIDE;
          end else begin
            tickCnt_d = tickCnt_q + 4'd1;
          end
        end
      end
      DECIDE: begin
        if (atPac) begin
          state_d = CAUGHT;
        end else if (openMask == 4'b0000) begin
          state_d = WAIT;
        end else begin
          heading_d = chosenDir;
          state_d   = MOVE;
        end
      end
      MOVE: begin
        // A restart request in this cycle cancels the step.
        if (!game_start) begin
          m_up    = (heading_q == DIR_UP);
          m_left  = (heading_q == DIR_LEFT);
          m_down  = (heading_q == DIR_DOWN);
          m_right = (heading_q == DIR_RIGHT);
        end
        state_d = SETTLE;
      end
      SETTLE:  state_d = atPac ? CAUGHT : WAIT;
      CAUGHT:  caught = 1'b1;
      default: state_d = IDLE;
    endcase
    if (game_start && (state_q != START)) state_d = START;
  end

endmodule

// File: tb/tb_ghost_chase_ctrl.sv
// Scoreboard bench for ghost_chase_ctrl: stimulus queues expected output events,
// a negedge monitor compares every pulse or caught change against the queue.
module tb_ghost_chase_ctrl;

  localparam logic [5:0] EV_START  = 6'b010000;
  localparam logic [5:0] EV_UP     = 6'b001000;
  localparam logic [5:0] EV_LEFT   = 6'b000100;
  localparam logic [5:0] EV_DOWN   = 6'b000010;
  localparam logic [5:0] EV_RIGHT  = 6'b000001;
  localparam logic [5:0] EV_CAUGHT = 6'b100000;

  logic       clk = 1'b0;
  logic       reset, tick, game_start;
  logic [9:0] xGhost, xPac;
  logic [8:0] yGhost, yPac;
  logic       open_up, open_left, open_down, open_right;
  logic       e_start, m_up, m_down, m_left, m_right, caught;

  logic [5:0] expQ[$];
  logic [5:0] monWord, monExp;
  logic       prevCaught = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  ghost_chase_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .game_start(game_start),
    .xGhost(xGhost), .yGhost(yGhost), .xPac(xPac), .yPac(yPac),
    .open_up(open_up), .open_left(open_left), .open_down(open_down), .open_right(open_right),
    .e_start(e_start), .m_up(m_up), .m_down(m_down), .m_left(m_left), .m_right(m_right),
    .caught(caught)
  );

  // Every output pulse or caught transition is an event that must match the queue head.
  always @(negedge clk) begin
    monWord = {caught, e_start, m_up, m_left, m_down, m_right};
    if ((monWord[4:0] != 5'b0) || (monWord[5] != prevCaught)) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_event actual=%b required=none t=%0t", monWord, $time);
      end else begin
        monExp = expQ.pop_front();
        if (monWord !== monExp) begin
          bad++;
          $display("[TB] FAIL event actual=%b required=%b t=%0t", monWord, monExp, $time);
        end
      end
    end
    prevCaught = monWord[5];
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [5:0] expWord);
    logic [5:0] act;
    act = {caught, e_start, m_up, m_left, m_down, m_right};
    total++;
    if (act !== expWord) begin
      bad++;
      $display("[TB] FAIL %s actual=%b required=%b", name, act, expWord);
    end
  endtask

  task automatic setPos(input int xg, input int yg, input int xp, input int yp);
    xGhost = 10'(xg);
    yGhost = 9'(yg);
    xPac   = 10'(xp);
    yPac   = 9'(yp);
  endtask

  task automatic setOpen(input logic [3:0] rdlu);
    {open_right, open_down, open_left, open_up} = rdlu;
  endtask

  // Issue n single-cycle ticks, each followed by gap quiet cycles.
  task automatic applyStimulus(input int n, input int gap);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(gap);
    end
  endtask

  task automatic pulseStart();
    game_start = 1'b1;
    cyc(1);
    game_start = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; game_start = 1'b0;
    setPos(46, 28, 50, 28);
    setOpen(4'b1111);
    cyc(3);
    reset = 1'b0;
    cyc(1);
    checkOutput("reset_idle", 6'b000000);
    applyStimulus(2, 2);
    checkOutput("idle_ignores_tick", 6'b000000);

    expQ.push_back(EV_START);
    pulseStart();
    checkOutput("after_start_wait", 6'b000000);

    // Heading up, Pac four columns right: step right on the fourth tick only.
    expQ.push_back(EV_RIGHT);
    applyStimulus(4, 4);

    // Heading right, only left open: forced reversal.
    setOpen(4'b0010);
    expQ.push_back(EV_LEFT);
    applyStimulus(4, 4);

    // Boxed in: no step at all.
    setOpen(4'b0000);
    applyStimulus(4, 4);

    // Heading left, dx=4 dy=2, right closed: second preference down.
    setPos(46, 26, 50, 28);
    setOpen(4'b0111);
    expQ.push_back(EV_DOWN);
    applyStimulus(4, 4);

    // Heading down, only up open: reversal upward.
    setPos(50, 30, 50, 28);
    setOpen(4'b0001);
    expQ.push_back(EV_UP);
    applyStimulus(4, 4);

    // Heading up, dx=3 dy=-3, up and right open: tie goes vertical.
    setPos(47, 31, 50, 28);
    setOpen(4'b1001);
    expQ.push_back(EV_UP);
    applyStimulus(4, 4);

    // Ghost lands on Pac in WAIT: caught next cycle and held through ticks.
    setOpen(4'b1111);
    expQ.push_back(EV_CAUGHT);
    setPos(50, 28, 50, 28);
    cyc(2);
    applyStimulus(4, 2);
    checkOutput("caught_held", 6'b100000);

    expQ.push_back(EV_START);
    setPos(46, 28, 50, 28);
    pulseStart();
    checkOutput("restart_clears_caught", 6'b000000);

    // game_start during MOVE cancels the step and restarts.
    expQ.push_back(EV_START);
    applyStimulus(3, 4);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    game_start = 1'b1;
    cyc(1);
    game_start = 1'b0;
    cyc(3);

    // Reset while MOVE is presenting m_right.
    expQ.push_back(EV_RIGHT);
    applyStimulus(3, 4);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    checkOutput("reset_mid_move", 6'b000000);
    applyStimulus(6, 2);

    // Restart from reset heading up: only left/down open, down is the reverse.
    setOpen(4'b0110);
    expQ.push_back(EV_START);
    pulseStart();
    expQ.push_back(EV_LEFT);
    applyStimulus(4, 4);

    cyc(6);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL missing_events actual=%0d required=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
